// File: rtl/pipe_root_reg_if.sv
// pipe_root_reg_if -- handshake bundle for the pipe_root_reg pipeline.
//
// Handshake rule, both ends: a word moves only on a rising clock edge where
// valid and ready are both high. valid must not depend on ready. ready may
// depend combinationally on valid.
//
// Signals:
//   in_valid / in_ready / in_data   upstream side (word entering stage 0)
//   out_valid / out_ready / out_data downstream side (word leaving last stage)
//   occupancy                        number of stages holding a valid word
//
// Modports:
//   master : environment side (drives in_*, out_ready)
//   slave  : pipeline side (drives in_ready, out_*, occupancy)
interface pipe_root_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_root_reg.sv
// pipe_root_reg -- DEPTH-stage valid/ready register pipeline with bubble
// compression, synchronous reset, flush and data preset.
//
// Ports:
//   clock  : sole clock, all state updates on its rising edge
//   reset  : synchronous active-high reset (highest priority)
//   flush  : synchronous discard of every in-flight word
//   set    : synchronous load of SET_VALUE into every stage's data word,
//            valid bits untouched
//   bus    : pipe_root_reg_if slave modport (in_*, out_*, occupancy)
//
// Priority: reset > flush > set > normal pipeline movement. While any of the
// three control inputs is high, in_ready and out_valid are forced low so no
// handshake can complete in that cycle.
module pipe_root_reg #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1),
  parameter logic [WIDTH-1:0] SET_VALUE   = ~WIDTH'(1)
) (
  input logic             clock,
  input logic             reset,
  input logic             set,
  input logic             flush,
  pipe_root_reg_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [DEPTH-1:0] stage_ready;
  logic             hold;
  logic             in_fire;
  logic             out_fire;

  assign hold = reset | flush | set;

  // Stage k is ready when it or any stage downstream of it is empty, or
  // when out_ready is high. Walking from the last stage back with a running
  // OR gives that without a self-referencing vector.
  always_comb begin
    logic r;
    r           = bus.out_ready;
    stage_ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r              = r | ~valid_q[k];
      stage_ready[k] = r;
    end
  end

  assign bus.in_ready  = stage_ready[0] & ~hold;
  assign bus.out_valid = valid_q[DEPTH-1] & ~hold;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.occupancy = occ_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      // Reset and flush leave the pipeline in the same empty state.
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
      occ_q <= '0;
    end else if (set) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= SET_VALUE;
    end else begin
      // A ready stage copies its upstream neighbour, bubbles included, so
      // data moves even when the valid bit being copied is clear.
      if (stage_ready[0]) begin
        valid_q[0] <= bus.in_valid;
        data_q[0]  <= bus.in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
        end
      end
      if (in_fire && !out_fire) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (out_fire && !in_fire) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end
  end
endmodule
